// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int unsigned NIB_W    = 4;
  localparam logic [2:0]  VEC_LAST = 3'd7;
  localparam int unsigned CNT_W    = 4;

  // Returns word with the nibble for vector idx replaced by nib.
  function automatic logic [31:0] put_nibble(input logic [31:0] word,
                                             input logic [2:0]  idx,
                                             input logic [3:0]  nib);
    logic [31:0] w;
    w = word;
    w[NIB_W*idx +: NIB_W] = nib;
    return w;
  endfunction

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable settle down-counter; stops at zero and flags it.
module tt_settle_cnt
  import tt_pkg::*;
#(
  parameter int unsigned Width = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps x/y/z through 000..111, samples o_in after a settle delay, packs a 32-bit table.
// Define TT_SWEEP_CHECK_EN to add the EXPECTED comparator with mismatch/err_cnt outputs.
module tt_sweep_ctrl
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
`ifdef TT_SWEEP_CHECK_EN
  ,
  parameter logic [31:0] EXPECTED = 32'h0707_8F80
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        x,
  output logic        y,
  output logic        z,
  input  logic [3:0]  o_in,
  output logic [2:0]  vec_idx,
  output logic        busy,
  output logic        done,
`ifdef TT_SWEEP_CHECK_EN
  output logic        mismatch,
  output logic [3:0]  err_cnt,
`endif
  output logic [31:0] table_out
);

  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  state_e      state_q;
  logic [2:0]  vec_idx_q;
  logic [31:0] table_q;
  logic        busy_q;
  logic        done_q;
  logic        cnt_zero;

  tt_settle_cnt #(
    .Width(CNT_W)
  ) u_settle_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == ST_DRIVE),
    .load_val(SettleLoad),
    .dec     (state_q == ST_SETTLE),
    .zero    (cnt_zero)
  );

`ifdef TT_SWEEP_CHECK_EN
  logic [3:0] err_q;
  logic       nib_diff;

  assign nib_diff = (o_in != EXPECTED[NIB_W*vec_idx_q +: NIB_W]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_idx_q <= '0;
      table_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TT_SWEEP_CHECK_EN
      err_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_DRIVE;
            vec_idx_q <= '0;
            table_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
`ifdef TT_SWEEP_CHECK_EN
            err_q     <= '0;
`endif
          end
        end
        ST_DRIVE: begin
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          table_q <= put_nibble(table_q, vec_idx_q, o_in);
`ifdef TT_SWEEP_CHECK_EN
          if (nib_diff) begin
            err_q <= err_q + 4'd1;
          end
`endif
          // Vector 7 is terminal: the index holds instead of wrapping.
          if (vec_idx_q == VEC_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            vec_idx_q <= vec_idx_q + 3'd1;
            state_q   <= ST_DRIVE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x         = vec_idx_q[2];
  assign y         = vec_idx_q[1];
  assign z         = vec_idx_q[0];
  assign vec_idx   = vec_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;

`ifdef TT_SWEEP_CHECK_EN
  assign err_cnt  = err_q;
  assign mismatch = done_q & (err_q != 4'd0);
`endif

endmodule
